// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the memory bus arbiter.
//   arb_state_t : arbiter FSM states (IDLE, ISSUE, RDATA)
//   M0 / M1     : requester identifiers (fetch / load-store)
//   BE_ALL      : all-ones byte-enable source; slice to the bus byte-enable width
package mem_bus_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RDATA = 2'd2
  } arb_state_t;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  // Wide enough for any practical data width; users take the low DATA_W/8 bits.
  localparam logic [127:0] BE_ALL = '1;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin pick (purely combinational).
// Ports:
//   elig0_i, elig1_i : requester 0 / 1 is eligible this cycle
//   last_grant_i     : id of the requester granted most recently
//   grant_valid_o    : at least one requester is eligible
//   grant_id_o       : id of the requester to grant (meaningful when grant_valid_o)
module rr_pick2 (
  input  logic elig0_i,
  input  logic elig1_i,
  input  logic last_grant_i,
  output logic grant_valid_o,
  output logic grant_id_o
);

  assign grant_valid_o = elig0_i | elig1_i;

  // Contention goes to whichever requester was not served last; otherwise the
  // single eligible requester wins (id 1 exactly when only elig1_i is set).
  assign grant_id_o = (elig0_i & elig1_i) ? ~last_grant_i : elig1_i;

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one Avalon-style memory bus between instruction fetch (M0, read-only)
// and the load/store unit (M1). One transfer is outstanding at a time; all bus
// outputs and acks are registered.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   m0_req/addr           : fetch request (held until m0_ack)
//   m0_ack/m0_rdata       : one-cycle completion pulse and fetched word
//   m1_req/we/addr/wdata/be : load/store request (held until m1_ack)
//   m1_ack/m1_rdata       : one-cycle completion pulse and load data
//   address/read/write/writedata/byteenable : bus master outputs
//   waitrequest           : slave stall; transfer accepted when strobe & !waitrequest
//   readdata              : valid the cycle after a read is accepted
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                m0_req,
  input  logic [ADDR_W-1:0]   m0_addr,
  output logic                m0_ack,
  output logic [DATA_W-1:0]   m0_rdata,
  input  logic                m1_req,
  input  logic                m1_we,
  input  logic [ADDR_W-1:0]   m1_addr,
  input  logic [DATA_W-1:0]   m1_wdata,
  input  logic [DATA_W/8-1:0] m1_be,
  output logic                m1_ack,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic [ADDR_W-1:0]   address,
  output logic                read,
  output logic                write,
  output logic [DATA_W-1:0]   writedata,
  output logic [DATA_W/8-1:0] byteenable,
  input  logic                waitrequest,
  input  logic [DATA_W-1:0]   readdata
);

  localparam int BE_W = DATA_W / 8;

  arb_state_t        state_q;
  logic              last_grant_q;
  logic              gid_q;
  logic [ADDR_W-1:0] address_q;
  logic              read_q;
  logic              write_q;
  logic [DATA_W-1:0] wdata_q;
  logic [BE_W-1:0]   be_q;
  logic              m0_ack_q;
  logic              m1_ack_q;
  logic [DATA_W-1:0] m0_rdata_q;
  logic [DATA_W-1:0] m1_rdata_q;

  logic elig0_d;
  logic elig1_d;
  logic grant_valid_d;
  logic grant_id_d;

  // A request still held during its own ack cycle is the tail of the
  // completed transfer, not a new request.
  assign elig0_d = m0_req & ~m0_ack_q;
  assign elig1_d = m1_req & ~m1_ack_q;

  rr_pick2 u_pick (
    .elig0_i       (elig0_d),
    .elig1_i       (elig1_d),
    .last_grant_i  (last_grant_q),
    .grant_valid_o (grant_valid_d),
    .grant_id_o    (grant_id_d)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= M1;
      gid_q        <= M0;
      address_q    <= '0;
      read_q       <= 1'b0;
      write_q      <= 1'b0;
      wdata_q      <= '0;
      be_q         <= '0;
      m0_ack_q     <= 1'b0;
      m1_ack_q     <= 1'b0;
      m0_rdata_q   <= '0;
      m1_rdata_q   <= '0;
    end else begin
      m0_ack_q <= 1'b0;
      m1_ack_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (grant_valid_d) begin
            gid_q        <= grant_id_d;
            last_grant_q <= grant_id_d;
            if (grant_id_d == M1) begin
              address_q <= m1_addr;
              write_q   <= m1_we;
              read_q    <= ~m1_we;
              wdata_q   <= m1_wdata;
              be_q      <= m1_be;
            end else begin
              address_q <= m0_addr;
              write_q   <= 1'b0;
              read_q    <= 1'b1;
              wdata_q   <= '0;
              be_q      <= BE_ALL[BE_W-1:0];
            end
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          // Fields are untouched while stalled, so the bus stays stable.
          if (!waitrequest) begin
            read_q  <= 1'b0;
            write_q <= 1'b0;
            if (write_q) begin
              m0_ack_q <= (gid_q == M0);
              m1_ack_q <= (gid_q == M1);
              state_q  <= IDLE;
            end else begin
              state_q <= RDATA;
            end
          end
        end
        RDATA: begin
          if (gid_q == M1) begin
            m1_rdata_q <= readdata;
            m1_ack_q   <= 1'b1;
          end else begin
            m0_rdata_q <= readdata;
            m0_ack_q   <= 1'b1;
          end
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign address    = address_q;
  assign read       = read_q;
  assign write      = write_q;
  assign writedata  = wdata_q;
  assign byteenable = be_q;
  assign m0_ack     = m0_ack_q;
  assign m1_ack     = m1_ack_q;
  assign m0_rdata   = m0_rdata_q;
  assign m1_rdata   = m1_rdata_q;

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single Avalon-style memory bus of mips_cpu_bus between two internal requesters: M0 is instruction fetch (read-only) and M1 is the data load/store unit.
- Arbitrates round-robin, drives one registered bus transfer at a time and holds it through waitrequest stalls.
- Captures read data, which arrives one cycle after acceptance, and returns a one-cycle ack to the requester that was granted.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width; byteenable width is DATA_W/8

Ports:
- clk  in  1  clock; all state changes on the rising edge
- reset  in  1  synchronous, active-high reset
- m0_req  in  1  fetch request; held until m0_ack
- m0_addr  in  ADDR_W  fetch byte address
- m0_ack  out  1  one-cycle pulse: fetch complete, m0_rdata valid
- m0_rdata  out  DATA_W  fetched word; holds its value until the next m0_ack
- m1_req  in  1  data request; held until m1_ack
- m1_we  in  1  1 = write, 0 = read
- m1_addr  in  ADDR_W  data byte address
- m1_wdata  in  DATA_W  store data
- m1_be  in  DATA_W/8  byte enables for both reads and writes
- m1_ack  out  1  one-cycle pulse: data access complete
- m1_rdata  out  DATA_W  load data; holds its value until the next m1_ack
- address  out  ADDR_W  bus address
- read  out  1  bus read strobe
- write  out  1  bus write strobe
- writedata  out  DATA_W  bus write data
- byteenable  out  DATA_W/8  bus byte enables
- waitrequest  in  1  slave stall; the transfer is accepted on the edge where the strobe is high and waitrequest is low
- readdata  in  DATA_W  valid in the cycle after a read is accepted

Behaviour:
- Reset (synchronous, active-high) takes effect at the next edge:
  - state = IDLE; read = write = 0; address, writedata and byteenable = 0
  - m0_ack = m1_ack = 0; m0_rdata = m1_rdata = 0
  - last_grant = M1, so M0 wins the first contention
  - Reset during ISSUE or RDATA abandons the transfer: strobes drop at that edge, no ack is issued and no rdata is updated.
- All bus outputs and acks are registered; there is no combinational path from any input to any output.
- States are IDLE, ISSUE and RDATA.
- IDLE:
  - Eligible requester: its req is high and its ack is low this cycle. A held req in the ack cycle is not a new request.
  - One eligible requester: grant it.
  - Both eligible: grant the one that is not last_grant.
  - On grant: latch address, write = m1_we (M1) or 0 (M0), read = !write, writedata = m1_wdata or 0, byteenable = m1_be or all-ones (M0); set last_grant; go to ISSUE.
- ISSUE:
  - Strobe and all bus fields stay stable while waitrequest = 1, for unbounded stalls.
  - On acceptance of a write: drop the strobe, pulse the granted ack next cycle, go to IDLE.
  - On acceptance of a read: drop the strobe, go to RDATA.
- RDATA:
  - Capture readdata into the granted requester's rdata register, pulse its ack, go to IDLE.
- Latency with no stalls, req seen at edge 0:
  - Write: strobe in cycle 1, ack in cycle 2.
  - Read: strobe in cycle 1, ack and rdata in cycle 3.
  - Each waitrequest cycle adds 1.
- Exactly one transfer is outstanding; read and write are never high together. Acks are mutually exclusive and high for exactly one cycle.
- Minimum IDLE dwell between transfers is 1 cycle, so bus strobes are never high on two consecutive transfers without a low cycle between them.
- Requester obligations: address, we, wdata and be are stable while req is high. Changes mid-transfer are ignored because fields are latched at grant.
- No address decode or translation; addresses pass through unchanged.

Decomposition:
- Package mem_bus_pkg holds:
  - arb_state_t enum {IDLE, ISSUE, RDATA}
  - localparams M0 = 1'b0, M1 = 1'b1
  - BE_ALL = all-ones byte enable
- One sub-module, rr_pick2: combinational two-way round-robin pick from (elig0, elig1, last_grant) giving (grant_valid, grant_id).
- FSM and datapath registers stay in mem_bus_arbiter.

Test Plan:
- Single fetch: m0_req with addr 0xBFC00000, waitrequest = 0, memory word 0x24020004 -> read = 1 in cycle 1 only; m0_ack in cycle 3 with m0_rdata = 0x24020004.
- Stalled store: m1 write addr 0xBFC00010, wdata 0xDEADBEEF, be 4'b0011, waitrequest high for 3 cycles -> write and all fields held stable for 4 cycles; m1_ack 1 cycle after acceptance; memory bytes written only per be.
- Contention: m0_req and m1_req held continuously from reset release -> grants alternate M0, M1, M0, M1; every ack is one cycle wide; no cycle has read and write both high.
- Read-after-ack hold: m1 read then m1 req held high in its ack cycle with no m0 request -> second transfer starts from IDLE one cycle later; m1_rdata holds the first value until the second ack.
- Reset mid-read: reset asserted in RDATA -> next cycle state IDLE, all strobes 0, m0_ack and m1_ack never pulse, both rdata = 0.
- Byte-lane load: m1 read with be 4'b1000 -> byteenable = 4'b1000 on the bus; m1_rdata[31:24] matches memory.
